texture_loader: RTL and testbench

//  Writer side of the wall-texture memory. Accepts a byte stream (valid/ready),

---
 rtl/texture_loader.sv | 96 +++++++++
 tb/tb_texture_loader.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/texture_loader.sv
// Writer side of the wall-texture memory: validates a one-byte header, then
// streams one texel per accepted byte into the texture RAM at {side,col,row}.
module texture_loader #(
  parameter int          CHANNEL_BITS = 2,
  parameter logic [7:0]  MAGIC        = 8'hA5
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic                      abort,
  input  logic [7:0]                in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic                      wr_en,
  output logic [12:0]               wr_addr,
  output logic [CHANNEL_BITS*3-1:0] wr_data,
  output logic                      busy,
  output logic                      done,
  output logic                      error,
  output logic [1:0]                dbg_state
);

  localparam int TW = CHANNEL_BITS * 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    LOAD = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t      state;
  logic [12:0] addr_ctr;
  logic        accept;

  // Stream handshake: a byte transfers on a rising clk edge exactly when
  // in_valid && in_ready; in_ready never depends on in_valid, and abort
  // withdraws readiness in the same cycle so the aborted byte is refused.
  assign in_ready  = ((state == HDR) || (state == LOAD)) && !abort;
  assign accept    = in_valid && in_ready;
  assign busy      = (state == HDR) || (state == LOAD);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      addr_ctr <= 13'd0;
      wr_en    <= 1'b0;
      wr_addr  <= 13'd0;
      wr_data  <= '0;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      done  <= 1'b0;
      if (abort) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE, ERR: begin
            if (start) begin
              state    <= HDR;
              addr_ctr <= 13'd0;
              error    <= 1'b0;
            end
          end
          HDR: begin
            if (accept) begin
              if (in_data == MAGIC) begin
                state <= LOAD;
              end else begin
                state <= ERR;
                error <= 1'b1;
              end
            end
          end
          LOAD: begin
            if (accept) begin
              wr_en    <= 1'b1;
              wr_addr  <= addr_ctr;
              wr_data  <= in_data[TW-1:0];
              addr_ctr <= addr_ctr + 13'd1;
              // Final texel: the counter wraps to 0 only as the load ends.
              if (addr_ctr == 13'h1FFF) begin
                state <= IDLE;
                done  <= 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_texture_loader.sv
// Bench for texture_loader: directed steps with random texel bytes and gaps,
// checked cycle by cycle against a behavioural model of the loader.
module tb_texture_loader;

  localparam int TW = 6;
  localparam int W  = 13 + TW;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'd0;
  logic          in_ready, wr_en, busy, done, error;
  logic [12:0]   wr_addr;
  logic [TW-1:0] wr_data;
  logic [1:0]    dbg_state;

  int total = 0;
  int bad   = 0;

  // Model: header expected, texels being loaded, sticky error, texel count.
  bit            m_hdr, m_load, m_err;
  int            m_cnt;
  logic          exp_ready, exp_we, exp_done;
  logic [12:0]   exp_addr;
  logic [TW-1:0] exp_data;
  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  wr_log[$];
  logic [W-1:0]  sb_item;
  int            we_cnt;
  logic [12:0]   cap65;
  logic          done_at_last;

  texture_loader #(.CHANNEL_BITS(2), .MAGIC(8'hA5)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .error(error), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_hdr = 0; m_load = 0; m_err = 0; m_cnt = 0;
    exp_we = 0; exp_done = 0; exp_addr = '0; exp_data = '0;
    exp_q.delete();
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic step(input logic st, input logic ab, input logic v, input logic [7:0] d);
    bit acc;
    start = st; abort = ab; in_valid = v; in_data = d;
    #1;
    exp_ready = (m_hdr || m_load) && !ab;
    chk("in_ready", in_ready, exp_ready);
    @(posedge clk);
    acc = v && exp_ready;
    exp_we = 0; exp_done = 0;
    if (ab) begin
      m_hdr = 0; m_load = 0;
    end else if (!m_hdr && !m_load) begin
      if (st) begin m_hdr = 1; m_err = 0; m_cnt = 0; end
    end else if (acc) begin
      if (m_hdr) begin
        m_hdr = 0;
        if (d == 8'hA5) m_load = 1; else m_err = 1;
      end else begin
        exp_we = 1; exp_addr = m_cnt[12:0]; exp_data = d[TW-1:0];
        exp_q.push_back({exp_addr, exp_data});
        if (m_cnt == 8191) begin exp_done = 1; m_load = 0; end
        m_cnt++;
      end
    end
    #1;
    chk("wr_en", wr_en, exp_we);
    chk("done", done, exp_done);
    chk("busy", busy, m_hdr || m_load);
    chk("error", error, m_err);
    chk("wr_addr", wr_addr, exp_addr);
    chk("wr_data", wr_data, exp_data);
    if (wr_en === 1'b1) begin
      we_cnt++;
      if (we_cnt == 66) cap65 = wr_addr;
      if (wr_addr == 13'h1FFF) done_at_last = done;
      wr_log.push_back({wr_addr, wr_data});
      chk("sb_pending", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        sb_item = exp_q.pop_front();
        chk("sb_write", {wr_addr, wr_data}, sb_item);
      end
    end
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_wr_en"}, wr_en, 0);
    chk({tag, "_wr_addr"}, wr_addr, 0);
    chk({tag, "_wr_data"}, wr_data, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_error"}, error, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
  endtask

  initial begin
    logic [7:0] b;
    model_reset();
    we_cnt = 0; cap65 = '0; done_at_last = 0;
    #1;
    check_reset_outputs("rst0");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    step(0, 0, 0, 8'h00);

    // Header then three texels back to back; upper byte bits are dropped.
    wr_log.delete();
    step(1, 0, 0, 8'h00);
    step(0, 0, 1, 8'hA5);
    step(0, 0, 1, 8'h3F);
    step(0, 0, 1, 8'hC1);
    step(0, 0, 1, 8'h15);
    step(0, 0, 0, 8'h00);
    chk("t2_count", wr_log.size(), 3);
    if (wr_log.size() >= 3) begin
      chk("t2_w0", wr_log[0], {13'd0, 6'h3F});
      chk("t2_w1", wr_log[1], {13'd1, 6'h01});
      chk("t2_w2", wr_log[2], {13'd2, 6'h15});
    end
    step(0, 1, 0, 8'h00);

    // Full load with random gaps in in_valid.
    we_cnt = 0; done_at_last = 0;
    step(1, 0, 0, 8'h00);
    step(0, 0, 1, 8'hA5);
    for (int i = 0; i < 40000 && m_cnt < 8192; i++) begin
      b = 8'($urandom);
      step(0, 0, ($urandom_range(0, 3) != 0), b);
    end
    step(0, 0, 1, 8'h11);
    step(0, 0, 0, 8'h00);
    chk("full_count", we_cnt, 8192);
    chk("full_addr65", cap65, {1'b0, 6'd1, 6'd1});
    chk("full_last_addr", wr_addr, 13'h1FFF);
    chk("full_done_last", done_at_last, 1);
    chk("full_busy_after", busy, 0);
    chk("full_ready_after", in_ready, 0);

    // Bad header goes to error; restart clears it.
    step(1, 0, 0, 8'h00);
    step(0, 0, 1, 8'h5A);
    step(0, 0, 1, 8'h07);
    step(0, 0, 1, 8'hA5);
    chk("t4_error", error, 1);
    chk("t4_ready", in_ready, 0);
    wr_log.delete();
    step(1, 0, 0, 8'h00);
    chk("t4_error_clr", error, 0);
    step(0, 0, 1, 8'hA5);
    step(0, 0, 1, 8'h07);
    chk("t4_write", {wr_addr, wr_data}, {13'd0, 6'h07});
    chk("t4_count", wr_log.size(), 1);
    step(0, 1, 0, 8'h00);

    // Abort after 100 texels with a byte on the bus.
    we_cnt = 0;
    step(1, 0, 0, 8'h00);
    step(0, 0, 1, 8'hA5);
    for (int i = 0; i < 100; i++) step(0, 0, 1, 8'($urandom));
    step(0, 1, 1, 8'h2A);
    chk("t5_busy", busy, 0);
    step(0, 0, 1, 8'h2B);
    chk("t5_count", we_cnt, 100);
    step(1, 0, 0, 8'h00);
    step(0, 0, 1, 8'hA5);
    step(0, 0, 1, 8'h33);
    chk("t5_restart", {wr_addr, wr_data}, {13'd0, 6'h33});
    step(0, 1, 0, 8'h00);

    // start during LOAD is ignored.
    step(1, 0, 0, 8'h00);
    step(0, 0, 1, 8'hA5);
    for (int i = 0; i < 10; i++) step(0, 0, 1, 8'($urandom));
    step(1, 0, 1, 8'h1C);
    chk("t6_addr", wr_addr, 13'd10);
    chk("t6_busy", busy, 1);

    // Asynchronous reset with a write in flight.
    step(0, 0, 1, 8'h3E);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    step(0, 0, 1, 8'h05);
    step(1, 0, 0, 8'h00);
    step(0, 0, 1, 8'hA5);
    step(0, 0, 1, 8'h09);
    chk("rst_restart", {wr_addr, wr_data}, {13'd0, 6'h09});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
